// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline hazard controller and the rest of the
// 5-stage core: ID/EX/MEM/WB control fields and the dmem ack come in, and
// the stall/flush/forward selects plus status flags go out.
interface pipe_hazard_ctrl_if;
    logic [4:0] rs1_D, rs2_D;
    logic [4:0] rs1_E, rs2_E, rd_E;
    logic [4:0] rd_M, rd_W;
    logic       result_src_E, reg_write_E, pc_src_E;
    logic       reg_write_M, reg_write_W;
    logic       mreq_M, dmem_ack;
    logic       stall_F, stall_D, stall_E, stall_M;
    logic       flush_D, flush_E, flush_W;
    logic [1:0] fwd_a_E, fwd_b_E;
    logic       mem_err, busy;

    // Pipeline side: drives the control fields, consumes the hazard controls.
    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        output result_src_E, reg_write_E, pc_src_E, reg_write_M, reg_write_W,
        output mreq_M, dmem_ack,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        input  fwd_a_E, fwd_b_E, mem_err, busy
    );

    // Controller side.
    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        input  result_src_E, reg_write_E, pc_src_E, reg_write_M, reg_write_W,
        input  mreq_M, dmem_ack,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        output fwd_a_E, fwd_b_E, mem_err, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the IF/ID/EX/MEM/WB pipeline.
// Resolves load-use stalls, taken branch flushes, EX operand forwarding and
// a multicycle data-memory wait with timeout (sticky mem_err, terminal ERR).
// Optional build macro HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt counters.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 64,  // cycles allowed in DWAIT, 2..65535
    parameter int unsigned CNT_W   = 16   // 2**CNT_W must exceed TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    // Counter value on the last permitted wait cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;

    logic             mem_wait;
    logic             load_use;
    logic             branch;

    // Memory wait FSM next state: ack always releases, even on the timeout cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        unique case (state_q)
            IDLE: begin
                if (hz.mreq_M && !hz.dmem_ack) begin
                    state_d    = DWAIT;
                    wait_cnt_d = '0;
                end
            end
            DWAIT: begin
                if (hz.dmem_ack) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == LAST_CNT) begin
                    state_d   = ERR;
                    mem_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                state_d = ERR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state, wait counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    // Hazard conditions; x0 never participates in a load-use match.
    always_comb begin
        mem_wait = ((state_q == IDLE)  && hz.mreq_M && !hz.dmem_ack) ||
                   ((state_q == DWAIT) && !hz.dmem_ack) ||
                   (state_q == ERR);
        load_use = hz.result_src_E && hz.reg_write_E && (hz.rd_E != 5'd0) &&
                   ((hz.rd_E == hz.rs1_D) || (hz.rd_E == hz.rs2_D));
        branch   = hz.pc_src_E;
    end

    // Stall/flush/forward outputs: reset forcing, then mem_wait > branch > load_use.
    always_comb begin
        hz.stall_F = 1'b0;
        hz.stall_D = 1'b0;
        hz.stall_E = 1'b0;
        hz.stall_M = 1'b0;
        hz.flush_D = 1'b0;
        hz.flush_E = 1'b0;
        hz.flush_W = 1'b0;
        hz.fwd_a_E = 2'b00;
        hz.fwd_b_E = 2'b00;
        hz.busy    = 1'b0;
        if (rst) begin
            hz.flush_D = 1'b1;
            hz.flush_E = 1'b1;
            hz.flush_W = 1'b1;
        end else begin
            hz.busy = (state_q != IDLE);
            if (mem_wait) begin
                // Whole front of the pipe freezes; a pending branch is held, not flushed.
                hz.stall_F = 1'b1;
                hz.stall_D = 1'b1;
                hz.stall_E = 1'b1;
                hz.stall_M = 1'b1;
                hz.flush_W = 1'b1;
            end else if (branch) begin
                hz.flush_D = 1'b1;
                hz.flush_E = 1'b1;
            end else if (load_use) begin
                hz.stall_F = 1'b1;
                hz.stall_D = 1'b1;
                hz.flush_E = 1'b1;
            end

            // Forwarding stays live while stalled so held EX operands refresh.
            if (hz.reg_write_M && (hz.rd_M != 5'd0) && (hz.rd_M == hz.rs1_E)) begin
                hz.fwd_a_E = 2'b10;
            end else if (hz.reg_write_W && (hz.rd_W != 5'd0) && (hz.rd_W == hz.rs1_E)) begin
                hz.fwd_a_E = 2'b01;
            end

            if (hz.reg_write_M && (hz.rd_M != 5'd0) && (hz.rd_M == hz.rs2_E)) begin
                hz.fwd_b_E = 2'b10;
            end else if (hz.reg_write_W && (hz.rd_W != 5'd0) && (hz.rd_W == hz.rs2_E)) begin
                hz.fwd_b_E = 2'b01;
            end
        end
    end

    assign hz.mem_err = mem_err_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        stall_evt;
    logic        flush_evt;

    // Only branch/load_use bubbles count as flushes; reset-forced flushes do not.
    assign stall_evt = !rst && (mem_wait || (!branch && load_use));
    assign flush_evt = !rst && !mem_wait && (branch || load_use);

    // Free-running performance counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_evt) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_evt) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a driver applies directed and random
// control fields each cycle and queues the outputs predicted by a behavioural
// model; a monitor pops and compares them independently.
module tb_pipe_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hif ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        bit       rst;
        bit [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        bit       ld_E, rw_E, pc, rw_M, rw_W, mreq, ack;
    } stim_t;

    typedef struct {
        bit [3:0]    stall;   // {F,D,E,M}
        bit [2:0]    flush;   // {D,E,W}
        bit [1:0]    fa, fb;
        bit          err, busy;
        int unsigned sc, fc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;

    // Reference model state: memory wait progress and sticky error.
    bit          m_waiting = 0;
    int          m_waited  = 0;
    bit          m_dead    = 0;
    bit          m_err     = 0;
    int unsigned m_sc      = 0;
    int unsigned m_fc      = 0;

    function automatic stim_t z();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit [1:0] fwd_of(bit [4:0] rs, stim_t s);
        if (rs != 0 && s.rw_M && s.rd_M == rs) return 2'b10;
        if (rs != 0 && s.rw_W && s.rd_W == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        bit   memstall, lu;
        @(negedge clk);
        rst              = s.rst;
        hif.rs1_D        = s.rs1_D;  hif.rs2_D = s.rs2_D;
        hif.rs1_E        = s.rs1_E;  hif.rs2_E = s.rs2_E;
        hif.rd_E         = s.rd_E;   hif.rd_M  = s.rd_M;  hif.rd_W = s.rd_W;
        hif.result_src_E = s.ld_E;   hif.reg_write_E = s.rw_E;
        hif.pc_src_E     = s.pc;
        hif.reg_write_M  = s.rw_M;   hif.reg_write_W = s.rw_W;
        hif.mreq_M       = s.mreq;   hif.dmem_ack    = s.ack;

        e       = '{default: 0};
        e.err   = m_err;
        e.sc    = m_sc;
        e.fc    = m_fc;
        if (s.rst) begin
            e.flush   = 3'b111;
            m_waiting = 0;
            m_waited  = 0;
            m_dead    = 0;
            m_err     = 0;
            m_sc      = 0;
            m_fc      = 0;
        end else begin
            memstall = m_dead || (!s.ack && (m_waiting || s.mreq));
            lu = s.ld_E && s.rw_E && s.rd_E != 0 && (s.rd_E == s.rs1_D || s.rd_E == s.rs2_D);
            if (memstall)  begin e.stall = 4'b1111; e.flush = 3'b001; end
            else if (s.pc) begin e.stall = 4'b0000; e.flush = 3'b110; end
            else if (lu)   begin e.stall = 4'b1100; e.flush = 3'b010; end
            e.fa   = fwd_of(s.rs1_E, s);
            e.fb   = fwd_of(s.rs2_E, s);
            e.busy = m_waiting || m_dead;
            if (e.stall[3]) m_sc++;
            if (!memstall && (s.pc || lu)) m_fc++;
            if (m_dead) begin
                // stays dead until reset
            end else if (m_waiting) begin
                if (s.ack) m_waiting = 0;
                else if (m_waited == TO - 1) begin
                    m_waiting = 0;
                    m_dead    = 1;
                    m_err     = 1;
                end else m_waited++;
            end else if (s.mreq && !s.ack) begin
                m_waiting = 1;
                m_waited  = 0;
            end
        end
        sbq.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    endtask

    // Monitor: outputs are combinational, so one expectation per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                cyc++;
                check("stall", {28'd0, hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M}, {28'd0, e.stall});
                check("flush", {29'd0, hif.flush_D, hif.flush_E, hif.flush_W}, {29'd0, e.flush});
                check("fwd_a", {30'd0, hif.fwd_a_E}, {30'd0, e.fa});
                check("fwd_b", {30'd0, hif.fwd_b_E}, {30'd0, e.fb});
                check("mem_err", {31'd0, hif.mem_err}, {31'd0, e.err});
                check("busy", {31'd0, hif.busy}, {31'd0, e.busy});
`ifdef HAZ_PERF_CNT_EN
                check("stall_cnt", stall_cnt, e.sc);
                check("flush_cnt", flush_cnt, e.fc);
`endif
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1;
        hif.rs1_D = 0; hif.rs2_D = 0; hif.rs1_E = 0; hif.rs2_E = 0;
        hif.rd_E = 0; hif.rd_M = 0; hif.rd_W = 0;
        hif.result_src_E = 0; hif.reg_write_E = 0; hif.pc_src_E = 0;
        hif.reg_write_M = 0; hif.reg_write_W = 0; hif.mreq_M = 0; hif.dmem_ack = 0;

        // reset
        s = z(); s.rst = 1; drive(s); drive(s);
        // load-use on rs1, then the load has moved on
        s = z(); s.rd_E = 5; s.ld_E = 1; s.rw_E = 1; s.rs1_D = 5; drive(s);
        s = z(); drive(s);
        // x0 load never stalls; MEM beats WB on forwarding
        s = z(); s.ld_E = 1; s.rw_E = 1; s.rd_E = 0; s.rs1_D = 0;
        s.rd_M = 7; s.rd_W = 7; s.rw_M = 1; s.rw_W = 1; s.rs2_E = 7; drive(s);
        s.rs1_E = 7; s.rw_M = 0; drive(s);
        // branch with load-use: branch wins
        s = z(); s.pc = 1; s.rd_E = 5; s.ld_E = 1; s.rw_E = 1; s.rs2_D = 5; drive(s);
        // 3-cycle memory wait with a held branch, released on ack
        s = z(); s.mreq = 1; s.pc = 1; repeat (3) drive(s);
        s.ack = 1; drive(s);
        s = z(); drive(s);
        // ack arrives on the last permitted wait cycle
        s = z(); s.mreq = 1; repeat (TO) drive(s);
        s.ack = 1; drive(s);
        s = z(); drive(s);
        // timeout into ERR, sticky until reset
        s = z(); s.mreq = 1; repeat (TO + 3) drive(s);
        s = z(); s.ack = 1; repeat (2) drive(s);
        s = z(); s.rst = 1; drive(s);
        s = z(); drive(s);
        // reset in the middle of a wait
        s = z(); s.mreq = 1; repeat (2) drive(s);
        s.rst = 1; drive(s);
        s.rst = 0; s.mreq = 0; drive(s);

        // randomized traffic on a small register set to provoke matches
        for (int i = 0; i < 2000; i++) begin
            s       = z();
            s.rst   = ($urandom_range(0, 99) < 4);
            s.rs1_D = 5'($urandom_range(0, 3)); s.rs2_D = 5'($urandom_range(0, 3));
            s.rs1_E = 5'($urandom_range(0, 3)); s.rs2_E = 5'($urandom_range(0, 3));
            s.rd_E  = 5'($urandom_range(0, 3)); s.rd_M  = 5'($urandom_range(0, 3));
            s.rd_W  = 5'($urandom_range(0, 3));
            s.ld_E  = ($urandom_range(0, 99) < 40);
            s.rw_E  = ($urandom_range(0, 99) < 70);
            s.rw_M  = ($urandom_range(0, 99) < 60);
            s.rw_W  = ($urandom_range(0, 99) < 60);
            s.pc    = ($urandom_range(0, 99) < 15);
            s.mreq  = ($urandom_range(0, 99) < 30);
            s.ack   = ($urandom_range(0, 99) < 40);
            drive(s);
        end

        @(negedge clk);
        #4;
        n_chk++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
